// File: rtl/rst_seq.sv
// Board reset sequencer: waits for clock lock, holds, waits for DDR2 calibration,
// then releases DDR2, peripheral and CPU resets in that order.
module rst_seq #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CALIB_TIMEOUT = 65535,
  parameter int unsigned STAGE_GAP     = 8
) (
  input  logic       wb_clk,
  input  logic       wb_rst_i,
  input  logic       locked_mcm,
  input  logic       ddr2_calib_done,
  input  logic       sw_rst_req,
  output logic       ddr2_rst_o,
  output logic       periph_rst_o,
  output logic       cpu_rst_o,
  output logic [2:0] seq_state_o,
  output logic       timeout_err_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    HOLD       = 3'd1,
    WAIT_CALIB = 3'd2,
    GAP        = 3'd3,
    RUN        = 3'd4,
    ERROR      = 3'd5
  } state_t;

  // Counter terminal values: a state lasting N cycles leaves when the count reaches N-1.
  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] CALIB_LAST = 24'(CALIB_TIMEOUT - 1);
  localparam logic [23:0] GAP_LAST   = 24'(STAGE_GAP - 1);

  logic        lock_meta_r;
  logic        lock_s;
  logic        calib_meta_r;
  logic        calib_s;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [23:0] cnt_r;
  logic [23:0] cnt_nxt_s;
  logic        set_err_s;
  logic        ddr2_rst_nxt_s;
  logic        periph_rst_nxt_s;
  logic        cpu_rst_nxt_s;
  logic        timeout_err_nxt_s;

  // Two-flop synchronizers for the asynchronous lock and calibration inputs
  always_ff @(posedge wb_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lock_meta_r  <= 1'b0;
      lock_s       <= 1'b0;
      calib_meta_r <= 1'b0;
      calib_s      <= 1'b0;
    end else begin
      lock_meta_r  <= locked_mcm;
      lock_s       <= lock_meta_r;
      calib_meta_r <= ddr2_calib_done;
      calib_s      <= calib_meta_r;
    end
  end

  // Next-state, shared counter and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = 24'd0;
    set_err_s   = 1'b0;
    if (sw_rst_req) begin
      state_nxt_s = WAIT_LOCK;
    end else if ((state_r != WAIT_LOCK) && !lock_s) begin
      state_nxt_s = WAIT_LOCK;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          if (lock_s) state_nxt_s = HOLD;
          else        state_nxt_s = WAIT_LOCK;
        end
        HOLD: begin
          if (cnt_r == HOLD_LAST) state_nxt_s = WAIT_CALIB;
          else                    cnt_nxt_s   = cnt_r + 24'd1;
        end
        WAIT_CALIB: begin
          if (calib_s) begin
            state_nxt_s = GAP;
          end else if (cnt_r == CALIB_LAST) begin
            state_nxt_s = ERROR;
            set_err_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + 24'd1;
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) state_nxt_s = RUN;
          else                   cnt_nxt_s   = cnt_r + 24'd1;
        end
        RUN:     state_nxt_s = RUN;
        ERROR:   state_nxt_s = ERROR;
        default: state_nxt_s = WAIT_LOCK;
      endcase
    end

    ddr2_rst_nxt_s    = (state_nxt_s == WAIT_LOCK) || (state_nxt_s == HOLD);
    periph_rst_nxt_s  = !((state_nxt_s == GAP) || (state_nxt_s == RUN));
    cpu_rst_nxt_s     = (state_nxt_s != RUN);
    // Only a software request clears the sticky flag synchronously; lock loss does not.
    if (sw_rst_req) timeout_err_nxt_s = 1'b0;
    else            timeout_err_nxt_s = timeout_err_o | set_err_s;
  end

  // State, counter and output registers, all updated on the same edge
  always_ff @(posedge wb_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r       <= WAIT_LOCK;
      cnt_r         <= 24'd0;
      ddr2_rst_o    <= 1'b1;
      periph_rst_o  <= 1'b1;
      cpu_rst_o     <= 1'b1;
      timeout_err_o <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      ddr2_rst_o    <= ddr2_rst_nxt_s;
      periph_rst_o  <= periph_rst_nxt_s;
      cpu_rst_o     <= cpu_rst_nxt_s;
      timeout_err_o <= timeout_err_nxt_s;
    end
  end

  assign seq_state_o = state_r;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a vector table for the nominal bring-up plus
// hand-written sequences for glitch, timeout, lock loss and async reset corners.
module tb_rst_seq;

  logic       wb_clk = 1'b0;
  logic       wb_rst_i, locked_mcm, ddr2_calib_done, sw_rst_req;
  logic       ddr2_rst_o, periph_rst_o, cpu_rst_o, timeout_err_o;
  logic [2:0] seq_state_o;
  logic       d_ddr2_rst, d_periph_rst, d_cpu_rst, d_timeout_err;
  logic [2:0] d_seq_state;
  logic [6:0] obs_s, obs_d;

  int checks = 0;
  int errors = 0;

  rst_seq #(.CALIB_TIMEOUT(100)) u_dut (
    .wb_clk(wb_clk), .wb_rst_i(wb_rst_i), .locked_mcm(locked_mcm),
    .ddr2_calib_done(ddr2_calib_done), .sw_rst_req(sw_rst_req),
    .ddr2_rst_o(ddr2_rst_o), .periph_rst_o(periph_rst_o), .cpu_rst_o(cpu_rst_o),
    .seq_state_o(seq_state_o), .timeout_err_o(timeout_err_o)
  );

  rst_seq u_dflt (
    .wb_clk(wb_clk), .wb_rst_i(wb_rst_i), .locked_mcm(locked_mcm),
    .ddr2_calib_done(ddr2_calib_done), .sw_rst_req(sw_rst_req),
    .ddr2_rst_o(d_ddr2_rst), .periph_rst_o(d_periph_rst), .cpu_rst_o(d_cpu_rst),
    .seq_state_o(d_seq_state), .timeout_err_o(d_timeout_err)
  );

  assign obs_s = {seq_state_o, ddr2_rst_o, periph_rst_o, cpu_rst_o, timeout_err_o};
  assign obs_d = {d_seq_state, d_ddr2_rst, d_periph_rst, d_cpu_rst, d_timeout_err};

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    int         n;
    logic       lock;
    logic       calib;
    logic       sw;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [6:0] ex(input logic [2:0] st, input logic ddr,
                                    input logic per, input logic cpu, input logic err);
    return {st, ddr, per, cpu, err};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {state,ddr,per,cpu,err}=%b want %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ddr_bad;
    // Nominal bring-up, lock applied just before edge k
    tbl[0]  = '{2,  1'b1, 1'b0, 1'b0, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, ex(3'd1, 1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[2]  = '{15, 1'b1, 1'b0, 1'b0, ex(3'd1, 1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[3]  = '{1,  1'b1, 1'b0, 1'b0, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0)};
    tbl[4]  = '{11, 1'b1, 1'b0, 1'b0, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0)};
    tbl[5]  = '{2,  1'b1, 1'b1, 1'b0, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0)};
    tbl[6]  = '{1,  1'b1, 1'b1, 1'b0, ex(3'd3, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[7]  = '{7,  1'b1, 1'b1, 1'b0, ex(3'd3, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[8]  = '{1,  1'b1, 1'b1, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[9]  = '{5,  1'b1, 1'b0, 1'b0, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[10] = '{1,  1'b1, 1'b0, 1'b1, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[11] = '{1,  1'b1, 1'b0, 1'b0, ex(3'd1, 1'b1, 1'b1, 1'b1, 1'b0)};

    wb_rst_i = 1'b1; locked_mcm = 1'b0; ddr2_calib_done = 1'b0; sw_rst_req = 1'b0;
    tick(2);
    chk("reset_state", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    chk("reset_state_dflt", obs_d, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    wb_rst_i = 1'b0;
    tick(3);
    chk("idle_no_lock", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));

    for (int i = 0; i < 12; i++) begin
      locked_mcm = tbl[i].lock; ddr2_calib_done = tbl[i].calib; sw_rst_req = tbl[i].sw;
      tick(tbl[i].n);
      chk($sformatf("nominal_vec%0d", i), obs_s, tbl[i].exp);
      chk($sformatf("nominal_vec%0d_dflt", i), obs_d, tbl[i].exp);
    end
    sw_rst_req = 1'b0;

    // Lock glitch at HOLD count 10: three low samples, then a full 16-cycle HOLD
    tick(10);
    locked_mcm = 1'b0;
    tick(2);
    chk("glitch_still_hold", obs_s, ex(3'd1, 1'b1, 1'b1, 1'b1, 1'b0));
    tick(1);
    chk("glitch_to_wait_lock", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    locked_mcm = 1'b1;
    tick(3);
    chk("glitch_rehold", obs_s, ex(3'd1, 1'b1, 1'b1, 1'b1, 1'b0));
    ddr_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (ddr2_rst_o !== 1'b1) ddr_bad = 1'b1;
    end
    chk("hold_restart_full", {seq_state_o, ddr_bad, 3'b000}, {3'd1, 1'b0, 3'b000});
    tick(1);
    chk("hold_restart_done", obs_s, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0));

    // Calibration timeout (100 cycles) then software clear
    tick(99);
    chk("timeout_minus1", obs_s, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    tick(1);
    chk("timeout_error", obs_s, ex(3'd5, 1'b0, 1'b1, 1'b1, 1'b1));
    chk("dflt_no_timeout", obs_d, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_clears_err", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    tick(117);
    chk("timeout_again", obs_s, ex(3'd5, 1'b0, 1'b1, 1'b1, 1'b1));
    locked_mcm = 1'b0;
    tick(3);
    chk("lockloss_keeps_err", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b1));
    #1 wb_rst_i = 1'b1;
    #1 chk("async_rst_clears_err", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    wb_rst_i = 1'b0;

    // Full bring-up with calibration already done, then lock loss in RUN
    locked_mcm = 1'b1; ddr2_calib_done = 1'b1;
    tick(28);
    chk("run_after_reset", obs_s, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    locked_mcm = 1'b0;
    tick(2);
    chk("lockloss_run_pre", obs_s, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("lockloss_run", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));

    // sw_rst_req and calib_s together in WAIT_CALIB: WAIT_LOCK wins
    locked_mcm = 1'b1; ddr2_calib_done = 1'b0;
    tick(19);
    chk("wc_reached", obs_s, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    ddr2_calib_done = 1'b1;
    tick(2);
    chk("wc_calib_pending", obs_s, ex(3'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_beats_calib", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    tick(18);
    chk("gap_reached", obs_s, ex(3'd3, 1'b0, 1'b0, 1'b1, 1'b0));

    // Asynchronous reset pulse between edges while in GAP
    #1 wb_rst_i = 1'b1;
    #1 chk("async_rst_in_gap", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    wb_rst_i = 1'b0;
    tick(2);
    chk("post_rst_wait_lock", obs_s, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 16: wb_clk cycles that the synchronized lock must stay stable before DDR2 reset release; legal range 1..2^24-1.
REQ-002 The module SHALL have parameter CALIB_TIMEOUT, default 65535: maximum wb_clk cycles spent waiting for DDR2 calibration; legal range 1..2^24-1.
REQ-003 The module SHALL have parameter STAGE_GAP, default 8: wb_clk cycles between peripheral reset release and CPU reset release; legal range 1..2^24-1.
REQ-004 Port: wb_clk  input  1  single clock for all logic.
REQ-005 Port: wb_rst_i  input  1  asynchronous, active-high reset, driven by the board reset generator.
REQ-006 Port: locked_mcm  input  1  clock-manager lock, asynchronous to wb_clk.
REQ-007 Port: ddr2_calib_done  input  1  DDR2 controller calibration complete, asynchronous to wb_clk.
REQ-008 Port: sw_rst_req  input  1  synchronous single-cycle software reset request.
REQ-009 Port: ddr2_rst_o  output  1  active-high DDR2 interface reset.
REQ-010 Port: periph_rst_o  output  1  active-high Wishbone peripheral reset.
REQ-011 Port: cpu_rst_o  output  1  active-high CPU reset.
REQ-012 Port: seq_state_o  output  3  current state encoding.
REQ-013 Port: timeout_err_o  output  1  sticky calibration-timeout flag.

Function
REQ-014 locked_mcm and ddr2_calib_done SHALL each pass through a 2-flop synchronizer (lock_s, calib_s); pin-to-lock_s latency is 2 wb_clk edges.
REQ-015 States and seq_state_o encodings SHALL be: WAIT_LOCK=0, HOLD=1, WAIT_CALIB=2, GAP=3, RUN=4, ERROR=5; codes 6-7 SHALL be unreachable and SHALL recover to WAIT_LOCK.
REQ-016 A single 24-bit counter SHALL be shared by all states and cleared on every state transition.
REQ-017 WAIT_LOCK: when lock_s=1, go to HOLD.
REQ-018 HOLD: increment the counter each cycle; after HOLD_CYCLES cycles in HOLD, go to WAIT_CALIB.
REQ-019 WAIT_CALIB: if calib_s=1, go to GAP; otherwise, after CALIB_TIMEOUT cycles, go to ERROR and set timeout_err_o.
REQ-020 GAP: after STAGE_GAP cycles, go to RUN.
REQ-021 RUN and ERROR SHALL hold until lock loss or sw_rst_req.
REQ-022 In any state other than WAIT_LOCK, lock_s=0 SHALL force WAIT_LOCK on the next edge.
REQ-023 sw_rst_req=1 SHALL force WAIT_LOCK from any state, including WAIT_LOCK itself, which restarts the sequence.
REQ-024 Priority SHALL be wb_rst_i > sw_rst_req > lock loss > calib_s > counter expiry.
REQ-025 Outputs SHALL be registered and SHALL change on the same edge as the state register.
- ddr2_rst_o = 1 in WAIT_LOCK and HOLD.
- periph_rst_o = 0 only in GAP and RUN.
- cpu_rst_o = 0 only in RUN.
- ERROR keeps ddr2_rst_o=0, periph_rst_o=1, cpu_rst_o=1.
REQ-026 Release order SHALL be DDR2, then peripherals, then CPU; all three resets SHALL reassert together on the transition into WAIT_LOCK.
REQ-027 timeout_err_o SHALL be cleared only by wb_rst_i or sw_rst_req; lock loss SHALL NOT clear it.
REQ-028 calib_s falling while in GAP or RUN SHALL be ignored.

Reset
REQ-029 While wb_rst_i=1, the block SHALL asynchronously hold the following values, and SHALL leave WAIT_LOCK only on a wb_clk edge after wb_rst_i deasserts:
- state WAIT_LOCK, seq_state_o=0
- counter 0, synchronizer flops 0
- ddr2_rst_o=1, periph_rst_o=1, cpu_rst_o=1, timeout_err_o=0
REQ-030 wb_rst_i asserted mid-sequence SHALL immediately reassert all resets, without waiting for a clock edge.

Verification
REQ-031 Nominal, defaults: locked_mcm rises before edge k, ddr2_calib_done high at edge k+30 -> ddr2_rst_o falls after edge k+18, periph_rst_o falls 3 edges after calib_done is sampled, cpu_rst_o falls 8 edges later, seq_state_o ends at 4.
REQ-032 Lock glitch: locked_mcm low for 3 cycles during HOLD at count 10 -> return to WAIT_LOCK, full 16-cycle HOLD restarts, ddr2_rst_o stays 1 throughout.
REQ-033 Timeout: CALIB_TIMEOUT=100, ddr2_calib_done held 0 -> ERROR (5) exactly 100 cycles after entering WAIT_CALIB, timeout_err_o=1, cpu_rst_o=1; then sw_rst_req pulse -> state 0, timeout_err_o=0.
REQ-034 Lock loss in RUN -> next edge after lock_s falls: seq_state_o=0 and all three resets=1 on the same edge.
REQ-035 Simultaneous events in WAIT_CALIB: sw_rst_req and calib_s rise in the same cycle -> WAIT_LOCK wins; also wb_rst_i pulsed between edges in GAP -> outputs reassert without a clock edge.
